// File: rtl/pos_link_if.sv
// Racket-position link signals: serial line in, validated position and status out.
// master = receiver driving the position outputs, slave = line driver / position consumer.
interface pos_link_if;
   logic       rx;
   logic [9:0] input_pos;
   logic       pos_valid;
   logic       frame_err;
   logic       link_up;

   modport master (input rx, output input_pos, pos_valid, frame_err, link_up);
   modport slave  (output rx, input input_pos, pos_valid, frame_err, link_up);
endinterface

// File: rtl/pos_link_rx.sv
// Receiver for the two-board racket link: 2-byte UART frames -> validated 10-bit Y position.
// Optional link timeout built only when PLINK_TIMEOUT_EN is defined.
//
// bit FSM state | meaning
// S_IDLE        | line idle, waiting for a falling edge
// S_START       | half a bit in, confirming the start bit
// S_DATA        | sampling 8 data bits, LSB first
// S_STOP        | sampling the stop bit
// S_BREAK       | low stop bit seen, waiting for the line to return high
//
// byte FSM state | meaning
// B_WAIT_HI      | expecting {1,00,pos[9:5]}
// B_WAIT_LO      | high part held, expecting {0,00,pos[4:0]}
module pos_link_rx #(
   parameter int         CLKS_PER_BIT = 564,
   parameter logic [9:0] DEFAULT_POS  = 10'd344
`ifdef PLINK_TIMEOUT_EN
   ,
   parameter int         TIMEOUT_CLKS = 6_500_000
`endif
) (
   input logic        clk65MHz,
   input logic        rst_n,
   pos_link_if.master link
);

   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_STOP  = 3'd3;
   localparam logic [2:0] S_BREAK = 3'd4;

   localparam logic [0:0] B_WAIT_HI = 1'b0;
   localparam logic [0:0] B_WAIT_LO = 1'b1;

   logic          rx_m, rx_s, rx_d;
   logic [2:0]    bit_st;
   logic [CW-1:0] bit_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          byte_done, stop_err;
   logic          hi_form, lo_form, pos_load;
   logic [0:0]    byte_st;
   logic [4:0]    hi_reg;
   logic [9:0]    pos_q;
   logic          valid_q, err_q, link_q;

   // rx_d only feeds the falling-edge detector; it resets high like the synchroniser
   always_ff @(posedge clk65MHz or negedge rst_n) begin
      if (!rst_n) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
         rx_d <= 1'b1;
      end else begin
         rx_m <= link.rx;
         rx_s <= rx_m;
         rx_d <= rx_s;
      end
   end

   always_ff @(posedge clk65MHz or negedge rst_n) begin
      if (!rst_n) begin
         bit_st  <= S_IDLE;
         bit_cnt <= '0;
         bit_idx <= '0;
         shreg   <= '0;
      end else begin
         case (bit_st)
            S_IDLE: begin
               if (rx_d && !rx_s) begin
                  bit_st  <= S_START;
                  bit_cnt <= HALF_LOAD;
               end
            end
            S_START: begin
               if (bit_cnt == '0) begin
                  if (!rx_s) begin
                     bit_st  <= S_DATA;
                     bit_cnt <= BIT_LOAD;
                     bit_idx <= '0;
                  end else begin
                     bit_st <= S_IDLE;
                  end
               end else begin
                  bit_cnt <= bit_cnt - CW'(1);
               end
            end
            S_DATA: begin
               if (bit_cnt == '0) begin
                  shreg   <= {rx_s, shreg[7:1]};
                  bit_cnt <= BIT_LOAD;
                  if (bit_idx == 3'd7) bit_st <= S_STOP;
                  else bit_idx <= bit_idx + 3'd1;
               end else begin
                  bit_cnt <= bit_cnt - CW'(1);
               end
            end
            S_STOP: begin
               if (bit_cnt == '0) bit_st <= rx_s ? S_IDLE : S_BREAK;
               else bit_cnt <= bit_cnt - CW'(1);
            end
            S_BREAK: begin
               if (rx_s) bit_st <= S_IDLE;
            end
            default: bit_st <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      byte_done = (bit_st == S_STOP) && (bit_cnt == '0) && rx_s;
      stop_err  = (bit_st == S_STOP) && (bit_cnt == '0) && !rx_s;
      hi_form   = shreg[7] && (shreg[6:5] == 2'b00);
      lo_form   = !shreg[7] && (shreg[6:5] == 2'b00);
      pos_load  = byte_done && (byte_st == B_WAIT_LO) && lo_form;
   end

`ifdef PLINK_TIMEOUT_EN
   localparam int TOW = $clog2(TIMEOUT_CLKS + 1);
   logic [TOW-1:0] to_cnt;
   logic           to_hit;

   // a frame error deliberately leaves the counter running
   always_ff @(posedge clk65MHz or negedge rst_n) begin
      if (!rst_n) to_cnt <= '0;
      else if (pos_load) to_cnt <= '0;
      else if (to_cnt != TOW'(TIMEOUT_CLKS)) to_cnt <= to_cnt + TOW'(1);
   end

   assign to_hit = (to_cnt == TOW'(TIMEOUT_CLKS - 1));
`endif

   always_ff @(posedge clk65MHz or negedge rst_n) begin
      if (!rst_n) begin
         byte_st <= B_WAIT_HI;
         hi_reg  <= '0;
         pos_q   <= DEFAULT_POS;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         link_q  <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         err_q   <= stop_err;
         if (byte_done) begin
            case (byte_st)
               B_WAIT_HI: begin
                  if (hi_form) begin
                     hi_reg  <= shreg[4:0];
                     byte_st <= B_WAIT_LO;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
               default: begin
                  if (lo_form) begin
                     byte_st <= B_WAIT_HI;
                  end else if (hi_form) begin
                     err_q  <= 1'b1;
                     hi_reg <= shreg[4:0];
                  end else begin
                     err_q   <= 1'b1;
                     byte_st <= B_WAIT_HI;
                  end
               end
            endcase
         end
         if (pos_load) begin
            pos_q   <= {hi_reg, shreg[4:0]};
            valid_q <= 1'b1;
            link_q  <= 1'b1;
         end
`ifdef PLINK_TIMEOUT_EN
         else if (to_hit) begin
            pos_q  <= DEFAULT_POS;
            link_q <= 1'b0;
         end
`endif
      end
   end

   assign link.input_pos = pos_q;
   assign link.pos_valid = valid_q;
   assign link.frame_err = err_q;
   assign link.link_up   = link_q;

endmodule

// File: tb/tb_pos_link_rx.sv
// Randomised scoreboard bench for pos_link_rx; expected strobes come from a byte-level frame model.
module tb_pos_link_rx;
   localparam int         CPB = 8;
   localparam int         TO  = 2000;
   localparam logic [9:0] DEF = 10'd344;
   localparam int         EV_ERR = -1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pos_link_if lnk ();

   pos_link_rx #(
      .CLKS_PER_BIT(CPB),
      .DEFAULT_POS (DEF)
`ifdef PLINK_TIMEOUT_EN
      ,
      .TIMEOUT_CLKS(TO)
`endif
   ) dut (
      .clk65MHz(clk),
      .rst_n   (rst_n),
      .link    (lnk)
   );

   int checks = 0;
   int failures = 0;
   int exp_q[$];
   bit m_wait_lo = 1'b0;
   logic [4:0] m_hi = '0;
   int m_last_pos = 344;
   int ev;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // frame rules applied to whole bytes: what strobe (if any) each byte must produce
   task automatic model_byte(input logic [7:0] b, input bit stop_ok);
      bit is_hi, is_lo;
      is_hi = (b[7:5] == 3'b100);
      is_lo = (b[7:5] == 3'b000);
      if (!stop_ok) begin
         exp_q.push_back(EV_ERR);
      end else if (!m_wait_lo) begin
         if (is_hi) begin
            m_hi = b[4:0];
            m_wait_lo = 1'b1;
         end else begin
            exp_q.push_back(EV_ERR);
         end
      end else if (is_lo) begin
         m_last_pos = int'({m_hi, b[4:0]});
         exp_q.push_back(m_last_pos);
         m_wait_lo = 1'b0;
      end else if (is_hi) begin
         exp_q.push_back(EV_ERR);
         m_hi = b[4:0];
      end else begin
         exp_q.push_back(EV_ERR);
         m_wait_lo = 1'b0;
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (lnk.pos_valid && lnk.frame_err) begin
            check("strobe_overlap", 1, 0);
         end else if (lnk.pos_valid || lnk.frame_err) begin
            if (exp_q.size() == 0) begin
               check("unexpected_strobe", lnk.pos_valid ? int'(lnk.input_pos) : EV_ERR, -2);
            end else begin
               ev = exp_q.pop_front();
               check("strobe_event", lnk.pos_valid ? int'(lnk.input_pos) : EV_ERR, ev);
               if (lnk.pos_valid) check("link_up_on_valid", int'(lnk.link_up), 1);
            end
         end
      end
   end

   task automatic drive_bit(input logic v);
      lnk.rx = v;
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit stop_ok);
      model_byte(b, stop_ok);
      @(posedge clk);
      #1;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      drive_bit(stop_ok);
   endtask

   task automatic send_frame(input logic [9:0] pos);
      send_byte({3'b100, pos[9:5]}, 1'b1);
      send_byte({3'b000, pos[4:0]}, 1'b1);
   endtask

   task automatic release_line(input int low_cycles);
      lnk.rx = 1'b0;
      repeat (low_cycles) @(posedge clk);
      #1;
      lnk.rx = 1'b1;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         @(posedge clk);
         n++;
      end
      repeat (3) @(posedge clk);
      #1;
      check(name, exp_q.size(), 0);
   endtask

   initial begin
      int sel;
      logic [7:0] rb;
      logic [9:0] rp;

      lnk.rx = 1'b1;
      rst_n  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_input_pos", int'(lnk.input_pos), 344);
      check("reset_pos_valid", int'(lnk.pos_valid), 0);
      check("reset_frame_err", int'(lnk.frame_err), 0);
      check("reset_link_up", int'(lnk.link_up), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;

      lnk.rx = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      lnk.rx = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      check("glitch_input_pos", int'(lnk.input_pos), 344);
      check("glitch_link_up", int'(lnk.link_up), 0);

      send_byte(8'h8A, 1'b1);
      send_byte(8'h0C, 1'b1);
      drain("drain_332");
      check("frame_332_pos", int'(lnk.input_pos), 332);
      check("frame_332_link", int'(lnk.link_up), 1);

      send_byte(8'h8A, 1'b0);
      release_line(40);
      send_frame(10'd100);
      drain("drain_stop_err");
      check("after_break_pos", int'(lnk.input_pos), 100);

      send_byte(8'h81, 1'b1);
      send_byte(8'h93, 1'b1);
      send_byte(8'h05, 1'b1);
      drain("drain_resync");
      check("resync_pos", int'(lnk.input_pos), 613);

      for (int it = 0; it < 40; it++) begin
         sel = $urandom_range(0, 9);
         rb  = 8'($urandom_range(0, 255));
         rp  = 10'($urandom_range(0, 1023));
         if (sel < 6) begin
            send_frame(rp);
         end else if (sel < 8) begin
            send_byte(rb, 1'b1);
         end else if (sel == 8) begin
            send_byte(rb, 1'b0);
            release_line($urandom_range(0, 30));
         end else begin
            send_byte({3'b100, rb[4:0]}, 1'b1);
         end
      end
      send_frame(10'd700);
      drain("drain_random");
      check("random_last_pos", int'(lnk.input_pos), m_last_pos);

      send_byte({3'b100, 5'd15}, 1'b1);
      @(posedge clk);
      #1;
      drive_bit(1'b0);
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b0);
      rst_n = 1'b0;
      m_wait_lo = 1'b0;
      #2;
      check("midreset_input_pos", int'(lnk.input_pos), 344);
      check("midreset_link_up", int'(lnk.link_up), 0);
      check("midreset_pos_valid", int'(lnk.pos_valid), 0);
      check("midreset_frame_err", int'(lnk.frame_err), 0);
      lnk.rx = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      send_frame(10'd500);
      drain("drain_after_reset");
      check("after_reset_pos", int'(lnk.input_pos), 500);
      check("after_reset_link", int'(lnk.link_up), 1);

      repeat (TO - 50) @(posedge clk);
      #1;
      check("pre_timeout_link", int'(lnk.link_up), 1);
      repeat (100) @(posedge clk);
      #1;
`ifdef PLINK_TIMEOUT_EN
      check("timeout_link", int'(lnk.link_up), 0);
      check("timeout_pos", int'(lnk.input_pos), 344);
`else
      check("sticky_link", int'(lnk.link_up), 1);
      check("sticky_pos", int'(lnk.input_pos), 500);
`endif
      check("final_queue", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
